axil_mem_ctrl: RTL and testbench
================================

AXIL_MEM_CTRL -- requirements
Module: axil_mem_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32: data width; SHALL be 32 or 64.
- ADDR_W, 32: AXI address width.
- DEPTH_WORDS, 1024: storage depth in DATA_W words; power of two.
- WAIT_STATES, 0: extra access cycles, 0..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: clock.
- RSTb, in, 1: reset, synchronous, active-low.
- mem_axi_awvalid / mem_axi_awready, in / out, 1: write-address handshake.
- mem_axi_awaddr, in, ADDR_W: byte address.
- mem_axi_awprot, in, 3: ignored.
- mem_axi_wvalid / mem_axi_wready, in / out, 1: write-data handshake.
- mem_axi_wdata, in, DATA_W: write data.
- mem_axi_wstrb, in, DATA_W/8: byte enables.
- mem_axi_bvalid / mem_axi_bready, out / in, 1: write response.
- mem_axi_bresp, out, 2: write status.
- mem_axi_arvalid / mem_axi_arready, in / out, 1: read-address handshake.
- mem_axi_araddr, in, ADDR_W: byte address.
- mem_axi_arprot, in, 3: ignored.
- mem_axi_rvalid / mem_axi_rready, out / in, 1: read data.
- mem_axi_rdata, out, DATA_W: read data.
- mem_axi_rresp, out, 2: read status.

Function
REQ-003 Internal storage SHALL be DEPTH_WORDS x DATA_W, word index = addr[log2(DATA_W/8) +: log2(DEPTH_WORDS)]; low byte-offset bits ignored.
REQ-004 FSM states SHALL be IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP; exactly one transaction in flight.
REQ-005 In IDLE, a write SHALL be accepted only when awvalid and wvalid are both high; awready and wready SHALL pulse high together for exactly that one cycle.
REQ-006 In IDLE, a read SHALL be accepted when arvalid is high; arready SHALL pulse high for that one cycle.
REQ-007 If write and read are both eligible in the same IDLE cycle, the grant SHALL alternate (round-robin); the first contention after reset SHALL grant read.
REQ-008 The write SHALL commit only the bytes with wstrb set; the write SHALL commit on the accept cycle.
REQ-009 The controller SHALL spend WAIT_STATES cycles in WR_WAIT/RD_WAIT, which are skipped when WAIT_STATES=0; bvalid/rvalid SHALL rise at accept+1+WAIT_STATES.
REQ-010 bvalid/rvalid with bresp/rresp/rdata SHALL hold stable until bready/rready is high, then the FSM SHALL return to IDLE the next cycle; a new accept SHALL NOT occur in the same cycle as the response handshake.
REQ-011 All ready signals SHALL be low outside IDLE; a ready SHALL never depend combinationally on its own valid beyond the IDLE gating.
REQ-012 A read of a word written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-013 While RSTb is low at a CLK edge, the FSM SHALL go to IDLE, all valid/ready outputs SHALL be 0, rdata 0, bresp/rresp 2'b00, and the round-robin flag SHALL reset to read-priority; storage contents are not cleared.
REQ-014 Reset mid-transaction SHALL abandon the transaction without a response; a write already committed stays committed.

Configuration
REQ-015 With AXIL_MEM_CTRL_RANGE_CHECK_EN defined, an address >= DEPTH_WORDS*(DATA_W/8) SHALL be accepted normally, suppress the write, return rdata 0, and give resp 2'b10 (SLVERR); in-range accesses give 2'b00.
REQ-016 Without AXIL_MEM_CTRL_RANGE_CHECK_EN, upper address bits SHALL be ignored (aliasing) and bresp/rresp SHALL be constant 2'b00.

Structure
REQ-017 A shared package axil_pkg SHALL hold the resp constants (OKAY=2'b00, SLVERR=2'b10) and the FSM state enum.
REQ-018 Storage SHALL be a sub-module axil_mem_ram (single-port, byte-write-enable, synchronous read); the FSM, arbiter and wait counter stay in the top level.

Verification
REQ-019 Write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 (WAIT_STATES=0) -> bvalid at accept+1, rdata=0xDEADBEEF, rresp=0.
REQ-020 Write 0xAABBCCDD to 0x20, then write 0x00001100 with wstrb=4'b0010, then read 0x20 -> 0xAABB11DD.
REQ-021 With WAIT_STATES=3, read -> rvalid exactly 4 cycles after arready; rready held low for 5 cycles -> rdata stable and rvalid held.
REQ-022 Write and read both valid every cycle for 4 transactions -> grants R,W,R,W.
REQ-023 With the macro defined and DEPTH_WORDS=1024, write 0x1234 to 0x1000, then read 0x1000 -> bresp=2'b10, rresp=2'b10, rdata=0, and word 0 unchanged. Without the macro, the same write lands in word 0.
REQ-024 Assert RSTb low during RD_WAIT -> no rvalid; after release, the next read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Definitions shared by the AXI4-Lite memory controller:
//               the AXI response codes and the controller FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_RESP = 3'd2,
        RD_WAIT = 3'd3,
        RD_RESP = 3'd4
    } axil_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : axil_mem_ram
// Description : Single-port RAM, DEPTH_WORDS x DATA_W.
//               Writes are per-byte masked.
//               Reads are synchronous and enable-gated. The output register
//               keeps its value until the next read, so it stays stable for
//               the whole of a read response.
// Ports       : clk     - clock
//               i_addr  - word index
//               i_we    - per-byte write enables
//               i_wdata - write data
//               i_rd_en - load o_rdata from i_addr on this edge
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module axil_mem_ram #(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH_WORDS = 1024,
    localparam int c_IDX_W     = $clog2(DEPTH_WORDS),
    localparam int c_STRB_W    = DATA_W / 8
) (
    input  logic                clk,
    input  logic [c_IDX_W-1:0]  i_addr,
    input  logic [c_STRB_W-1:0] i_we,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_rd_en,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Storage is never reset: contents must survive RSTb.
    always_ff @(posedge clk) begin
        for (int b = 0; b < c_STRB_W; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axil_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axil_mem_ctrl
// Description : AXI4-Lite slave in front of an on-chip RAM.
//               Only one transaction is in flight at a time.
//               Write/read contention is resolved round-robin, and the first
//               contention after reset grants the read.
//               WAIT_STATES adds extra access cycles before each response.
//               Define AXIL_MEM_CTRL_RANGE_CHECK_EN to enable the range check.
//               With it, out-of-range accesses return SLVERR, writes are
//               dropped and reads return 0. Without it, upper address bits
//               alias and every response is OKAY.
// Ports       : CLK, RSTb (sync, active-low)
//               mem_axi_aw*/w*/b* - write address / data / response channels
//               mem_axi_ar*/r*    - read address / data channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_mem_ctrl
    import axil_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic                  mem_axi_awvalid,
    output logic                  mem_axi_awready,
    input  logic [ADDR_W-1:0]     mem_axi_awaddr,
    input  logic [2:0]            mem_axi_awprot,
    input  logic                  mem_axi_wvalid,
    output logic                  mem_axi_wready,
    input  logic [DATA_W-1:0]     mem_axi_wdata,
    input  logic [DATA_W/8-1:0]   mem_axi_wstrb,
    output logic                  mem_axi_bvalid,
    input  logic                  mem_axi_bready,
    output logic [1:0]            mem_axi_bresp,
    input  logic                  mem_axi_arvalid,
    output logic                  mem_axi_arready,
    input  logic [ADDR_W-1:0]     mem_axi_araddr,
    input  logic [2:0]            mem_axi_arprot,
    output logic                  mem_axi_rvalid,
    input  logic                  mem_axi_rready,
    output logic [DATA_W-1:0]     mem_axi_rdata,
    output logic [1:0]            mem_axi_rresp
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] c_WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    axil_state_t r_state;
    axil_state_t w_state_nxt;
    logic        r_wr_pri;      // 1: the next contention goes to the write
    logic [3:0]  r_wait_cnt;
    logic        r_err;         // the transaction in flight is out of range

    logic               w_wr_elig;
    logic               w_rd_elig;
    logic               w_grant_wr;
    logic               w_grant_rd;
    logic               w_aw_oor;
    logic               w_ar_oor;
    logic [c_IDX_W-1:0] w_ram_addr;
    logic [c_STRB_W-1:0] w_ram_we;
    logic [DATA_W-1:0]  w_ram_q;

    // Acceptance is gated by RSTb so that nothing commits while in reset.
    assign w_wr_elig  = RSTb && (r_state == IDLE) && mem_axi_awvalid && mem_axi_wvalid;
    assign w_rd_elig  = RSTb && (r_state == IDLE) && mem_axi_arvalid;
    assign w_grant_wr = w_wr_elig && (!w_rd_elig || r_wr_pri);
    assign w_grant_rd = w_rd_elig && (!w_wr_elig || !r_wr_pri);

`ifdef AXIL_MEM_CTRL_RANGE_CHECK_EN
    // A non-zero bit above the word-index field means the address is outside the array.
    generate
        if (ADDR_W > c_OFF_W + c_IDX_W) begin : g_range
            assign w_aw_oor = |mem_axi_awaddr[ADDR_W-1:c_OFF_W+c_IDX_W];
            assign w_ar_oor = |mem_axi_araddr[ADDR_W-1:c_OFF_W+c_IDX_W];
        end else begin : g_no_range
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    // The RAM has a single port, which the granted channel drives.
    assign w_ram_addr = w_grant_wr ? mem_axi_awaddr[c_OFF_W +: c_IDX_W]
                                   : mem_axi_araddr[c_OFF_W +: c_IDX_W];
    assign w_ram_we   = (w_grant_wr && !w_aw_oor) ? mem_axi_wstrb : '0;

    axil_mem_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (CLK),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (mem_axi_wdata),
        .i_rd_en (w_grant_rd),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = (WAIT_STATES == 0) ? WR_RESP : WR_WAIT;
                end else if (w_grant_rd) begin
                    w_state_nxt = (WAIT_STATES == 0) ? RD_RESP : RD_WAIT;
                end
            end
            WR_WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = WR_RESP;
            RD_WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = RD_RESP;
            WR_RESP: if (mem_axi_bready) w_state_nxt = IDLE;
            RD_RESP: if (mem_axi_rready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state    <= IDLE;
            r_wr_pri   <= 1'b0;
            r_wait_cnt <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Priority flips only on real contention, handing the next tie to the loser.
            if (w_wr_elig && w_rd_elig) begin
                r_wr_pri <= w_grant_rd;
            end
            if (w_grant_wr || w_grant_rd) begin
                r_wait_cnt <= c_WS_LOAD;
                r_err      <= w_grant_wr ? w_aw_oor : w_ar_oor;
            end else if (((r_state == WR_WAIT) || (r_state == RD_WAIT)) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    assign mem_axi_awready = w_grant_wr;
    assign mem_axi_wready  = w_grant_wr;
    assign mem_axi_arready = w_grant_rd;
    assign mem_axi_bvalid  = (r_state == WR_RESP);
    assign mem_axi_rvalid  = (r_state == RD_RESP);
    assign mem_axi_bresp   = ((r_state == WR_RESP) && r_err) ? SLVERR : OKAY;
    assign mem_axi_rresp   = ((r_state == RD_RESP) && r_err) ? SLVERR : OKAY;
    // The RAM output holds its value through the response; outside it, rdata is forced to 0.
    assign mem_axi_rdata   = ((r_state == RD_RESP) && !r_err) ? w_ram_q : '0;

    // Protection bits and the byte-offset / aliased address bits carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr, mem_axi_araddr};

endmodule
`default_nettype wire

// File: tb/tb_axil_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_mem_ctrl
// Description : Self-checking bench for axil_mem_ctrl. Instance 0 uses
//               WAIT_STATES=0 and instance 1 uses WAIT_STATES=3. Expected
//               data comes from a word-array model of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_mem_ctrl;

    logic CLK = 1'b0;
    logic RSTb;
    always #5 CLK = ~CLK;

    logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
    logic        arvalid [2], arready [2], rvalid [2], rready [2];
    logic [31:0] awaddr [2], araddr [2], wdata [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [2:0]  prot;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [1024];
    bit          model_wr_pri;

    axil_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]), .mem_axi_awaddr(awaddr[0]),
        .mem_axi_awprot(prot), .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]),
        .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]), .mem_axi_bvalid(bvalid[0]),
        .mem_axi_bready(bready[0]), .mem_axi_bresp(bresp[0]), .mem_axi_arvalid(arvalid[0]),
        .mem_axi_arready(arready[0]), .mem_axi_araddr(araddr[0]), .mem_axi_arprot(prot),
        .mem_axi_rvalid(rvalid[0]), .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]),
        .mem_axi_rresp(rresp[0]));

    axil_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut_ws (
        .CLK(CLK), .RSTb(RSTb),
        .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]), .mem_axi_awaddr(awaddr[1]),
        .mem_axi_awprot(prot), .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]),
        .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]), .mem_axi_bvalid(bvalid[1]),
        .mem_axi_bready(bready[1]), .mem_axi_bresp(bresp[1]), .mem_axi_arvalid(arvalid[1]),
        .mem_axi_arready(arready[1]), .mem_axi_araddr(araddr[1]), .mem_axi_arprot(prot),
        .mem_axi_rvalid(rvalid[1]), .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]),
        .mem_axi_rresp(rresp[1]));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] m = old;
        for (int b = 0; b < 4; b++) if (strb[b]) m[b*8 +: 8] = nw[b*8 +: 8];
        return m;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        logic [31:0] a = addr;
        return int'(a[11:2]);
    endfunction

    task automatic apply_reset();
        for (int d = 0; d < 2; d++) begin
            awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 0; rready[d] = 0;
        end
        RSTb = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTb = 1'b1;
        model_wr_pri = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold,
                            output int lat, output logic [1:0] resp, output bit stable);
        int n = 0;
        bit acc = 0;
        lat = -1; resp = 2'bxx; stable = 1;
        awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
        awvalid[d] = 1; wvalid[d] = 1; bready[d] = 0;
        while (!acc && n < 20) begin
            #1 acc = awready[d] && wready[d];
            @(posedge CLK); #1; n++;
        end
        awvalid[d] = 0; wvalid[d] = 0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL wr_accept_timeout dut%0d addr=%h: no awready/wready, required within 20 cycles", d, addr);
            return;
        end
        n = 0;
        while (!bvalid[d] && n < 40) begin @(posedge CLK); #1; n++; end
        if (!bvalid[d]) begin
            n_tests++; n_fail++;
            $display("FAIL wr_resp_timeout dut%0d addr=%h: bvalid=0, required 1 within 40 cycles", d, addr);
            return;
        end
        lat = n; resp = bresp[d];
        repeat (hold) begin
            @(posedge CLK); #1;
            if (!bvalid[d] || bresp[d] !== resp) stable = 0;
        end
        bready[d] = 1; @(posedge CLK); #1; bready[d] = 0;
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                           output int lat, output logic [31:0] data, output logic [1:0] resp,
                           output bit stable);
        int n = 0;
        bit acc = 0;
        lat = -1; data = 'x; resp = 2'bxx; stable = 1;
        araddr[d] = addr; arvalid[d] = 1; rready[d] = 0;
        while (!acc && n < 20) begin
            #1 acc = arready[d];
            @(posedge CLK); #1; n++;
        end
        arvalid[d] = 0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL rd_accept_timeout dut%0d addr=%h: no arready, required within 20 cycles", d, addr);
            return;
        end
        n = 0;
        while (!rvalid[d] && n < 40) begin @(posedge CLK); #1; n++; end
        if (!rvalid[d]) begin
            n_tests++; n_fail++;
            $display("FAIL rd_resp_timeout dut%0d addr=%h: rvalid=0, required 1 within 40 cycles", d, addr);
            return;
        end
        lat = n; data = rdata[d]; resp = rresp[d];
        repeat (hold) begin
            @(posedge CLK); #1;
            if (!rvalid[d] || rdata[d] !== data || rresp[d] !== resp) stable = 0;
        end
        rready[d] = 1; @(posedge CLK); #1; rready[d] = 0;
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 0; rready[d] = 0;
            awaddr[d] = 0; araddr[d] = 0; wdata[d] = 0; wstrb[d] = 0;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d]} !== 5'b0) begin
                n_fail++; $display("FAIL reset_handshake dut%0d got %b required 00000", d,
                                   {awready[d], wready[d], arready[d], bvalid[d], rvalid[d]});
            end
            n_tests++;
            if (rdata[d] !== 32'h0 || bresp[d] !== 2'b00 || rresp[d] !== 2'b00) begin
                n_fail++; $display("FAIL reset_data dut%0d rdata=%h bresp=%b rresp=%b required 0/00/00",
                                   d, rdata[d], bresp[d], rresp[d]);
            end
        end
        #1 RSTb = 1'b1;
        model_wr_pri = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic [1:0] rs; bit st;
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rs, st);
        model_mem[widx(32'h10)] = 32'hDEADBEEF;
        n_tests++;
        if (lat !== 0) begin n_fail++; $display("FAIL basic_wr_latency got %0d required 0", lat); end
        n_tests++;
        if (rs !== 2'b00) begin n_fail++; $display("FAIL basic_bresp got %b required 00", rs); end
        n_tests++;
        if (bvalid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_bvalid_drop got %b required 0", bvalid[0]); end
        do_read(0, 32'h10, 0, lat, rd, rs, st);
        n_tests++;
        if (lat !== 0) begin n_fail++; $display("FAIL basic_rd_latency got %0d required 0", lat); end
        n_tests++;
        if (rd !== 32'hDEADBEEF || rs !== 2'b00) begin
            n_fail++; $display("FAIL basic_rdata got %h/%b required deadbeef/00", rd, rs);
        end
    endtask

    task automatic test_strobe();
        int lat; logic [31:0] rd, a, v; logic [3:0] s; logic [1:0] rs; bit st;
        do_write(0, 32'h20, 32'hAABBCCDD, 4'hF, 0, lat, rs, st);
        do_write(0, 32'h20, 32'h00001100, 4'b0010, 1, lat, rs, st);
        do_read(0, 32'h20, 0, lat, rd, rs, st);
        model_mem[widx(32'h20)] = 32'hAABB11DD;
        n_tests++;
        if (rd !== 32'hAABB11DD) begin n_fail++; $display("FAIL strobe_fixed got %h required aabb11dd", rd); end
        // Known contents for words 0..15, then random partial writes with random response stalls.
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            do_write(0, 32'(i * 4), v, 4'hF, 0, lat, rs, st);
            model_mem[i] = v;
        end
        for (int i = 0; i < 10; i++) begin
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            v = $urandom; s = 4'($urandom);
            do_write(0, a, v, s, $urandom_range(0, 3), lat, rs, st);
            model_mem[widx(a)] = merge(model_mem[widx(a)], v, s);
            n_tests++;
            if (!st || rs !== 2'b00) begin n_fail++; $display("FAIL strobe_bresp_hold stable=%0d bresp=%b required 1/00", st, rs); end
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            do_read(0, a, $urandom_range(0, 3), lat, rd, rs, st);
            n_tests++;
            if (rd !== model_mem[widx(a)] || !st) begin
                n_fail++; $display("FAIL strobe_rand addr=%h got %h stable=%0d required %h stable=1", a, rd, st, model_mem[widx(a)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int grants = 0, n = 0;
        bit got_r, got_w, rd_pend = 0, wr_pend = 0;
        logic [31:0] exp_rd = 0, a;
        apply_reset();
        bready[0] = 1; rready[0] = 1;
        awaddr[0] = {26'd0, 4'($urandom), 2'b00}; wdata[0] = $urandom; wstrb[0] = 4'($urandom);
        araddr[0] = {26'd0, 4'($urandom), 2'b00};
        awvalid[0] = 1; wvalid[0] = 1; arvalid[0] = 1;
        while ((grants < 8 || rd_pend || wr_pend) && n < 100) begin
            #1;
            if (rvalid[0]) begin
                n_tests++;
                if (!rd_pend || rdata[0] !== exp_rd) begin
                    n_fail++; $display("FAIL b2b_rdata got %h pending=%0d required %h", rdata[0], rd_pend, exp_rd);
                end
                rd_pend = 0;
            end
            if (bvalid[0]) begin
                n_tests++;
                if (!wr_pend) begin n_fail++; $display("FAIL b2b_bvalid got 1 required 0 (no write pending)"); end
                wr_pend = 0;
            end
            got_r = arready[0];
            got_w = awready[0] && wready[0];
            if (got_r || got_w) begin
                n_tests++;
                if (got_r == got_w || got_r != !model_wr_pri) begin
                    n_fail++; $display("FAIL b2b_grant #%0d got r=%0d w=%0d required %s", grants, got_r, got_w,
                                       model_wr_pri ? "W" : "R");
                end
                if (got_r) begin
                    a = araddr[0]; exp_rd = model_mem[widx(a)]; rd_pend = 1;
                end else begin
                    a = awaddr[0]; model_mem[widx(a)] = merge(model_mem[widx(a)], wdata[0], wstrb[0]); wr_pend = 1;
                end
                model_wr_pri = got_r;
                grants++;
            end
            @(posedge CLK); #1; n++;
            if (got_r) araddr[0] = {26'd0, 4'($urandom), 2'($urandom)};
            if (got_w) begin
                awaddr[0] = {26'd0, 4'($urandom), 2'($urandom)}; wdata[0] = $urandom; wstrb[0] = 4'($urandom);
            end
            if (grants >= 8) begin awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0; end
        end
        n_tests++;
        if (grants != 8 || rd_pend || wr_pend) begin
            n_fail++; $display("FAIL b2b_progress got %0d grants required 8 with all responses", grants);
        end
        awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0; bready[0] = 0; rready[0] = 0;
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic [1:0] rs, wb; bit st;
        do_write(0, 32'h0, 32'hCAFEF00D, 4'hF, 0, lat, rs, st);
        do_write(0, 32'h1000, 32'h00001234, 4'hF, 0, lat, wb, st);
`ifdef AXIL_MEM_CTRL_RANGE_CHECK_EN
        n_tests++;
        if (wb !== 2'b10) begin n_fail++; $display("FAIL range_bresp got %b required 10", wb); end
        do_read(0, 32'h1000, 1, lat, rd, rs, st);
        n_tests++;
        if (rs !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL range_read got %h/%b required 0/10", rd, rs); end
        model_mem[0] = 32'hCAFEF00D;
`else
        n_tests++;
        if (wb !== 2'b00) begin n_fail++; $display("FAIL range_bresp got %b required 00", wb); end
        do_read(0, 32'h1000, 1, lat, rd, rs, st);
        n_tests++;
        if (rs !== 2'b00 || rd !== 32'h1234) begin n_fail++; $display("FAIL range_alias_read got %h/%b required 1234/00", rd, rs); end
        model_mem[0] = 32'h00001234;
`endif
        do_read(0, 32'h0, 0, lat, rd, rs, st);
        n_tests++;
        if (rd !== model_mem[0] || rs !== 2'b00) begin
            n_fail++; $display("FAIL range_word0 got %h/%b required %h/00", rd, rs, model_mem[0]);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] rd, v; logic [1:0] rs; bit st;
        v = $urandom;
        do_write(1, 32'h40, v, 4'hF, 2, lat, rs, st);
        n_tests++;
        if (lat !== 3 || rs !== 2'b00 || !st) begin
            n_fail++; $display("FAIL ws_write lat=%0d bresp=%b stable=%0d required 3/00/1", lat, rs, st);
        end
        do_read(1, 32'h40, 5, lat, rd, rs, st);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL ws_rd_latency got %0d required 3", lat); end
        n_tests++;
        if (rd !== v || rs !== 2'b00 || !st) begin
            n_fail++; $display("FAIL ws_rd_hold got %h/%b stable=%0d required %h/00/1", rd, rs, st, v);
        end
        n_tests++;
        if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL ws_rvalid_drop got %b required 0", rvalid[1]); end
    endtask

    task automatic test_reset_midflight();
        int lat, n; logic [31:0] rd, v, old; logic [1:0] rs; bit st, acc, seen;
        do_read(1, 32'h40, 0, lat, old, rs, st);
        // Write abandoned in WR_WAIT: no response, data already committed.
        v = $urandom;
        awaddr[1] = 32'h44; wdata[1] = v; wstrb[1] = 4'hF; awvalid[1] = 1; wvalid[1] = 1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin #1 acc = awready[1]; @(posedge CLK); #1; n++; end
        awvalid[1] = 0; wvalid[1] = 0;
        @(posedge CLK); #1 RSTb = 0;
        @(posedge CLK); #1 RSTb = 1;
        seen = 0;
        repeat (6) begin @(posedge CLK); #1; if (bvalid[1]) seen = 1; end
        n_tests++;
        if (!acc || seen) begin n_fail++; $display("FAIL midwr_no_bvalid accepted=%0d bvalid_seen=%0d required 1/0", acc, seen); end
        do_read(1, 32'h44, 0, lat, rd, rs, st);
        n_tests++;
        if (rd !== v) begin n_fail++; $display("FAIL midwr_committed got %h required %h", rd, v); end
        // Read abandoned in RD_WAIT.
        araddr[1] = 32'h40; arvalid[1] = 1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin #1 acc = arready[1]; @(posedge CLK); #1; n++; end
        arvalid[1] = 0;
        @(posedge CLK); #1 RSTb = 0;
        seen = rvalid[1];
        @(posedge CLK); #1 RSTb = 1;
        repeat (6) begin @(posedge CLK); #1; if (rvalid[1]) seen = 1; end
        n_tests++;
        if (!acc || seen) begin n_fail++; $display("FAIL midrd_no_rvalid accepted=%0d rvalid_seen=%0d required 1/0", acc, seen); end
        do_read(1, 32'h40, 0, lat, rd, rs, st);
        n_tests++;
        if (rd !== old || lat !== 3 || rs !== 2'b00) begin
            n_fail++; $display("FAIL midrd_recover got %h lat=%0d resp=%b required %h/3/00", rd, lat, rs, old);
        end
    endtask

    initial begin
        prot = 3'b000;
        test_reset();
        test_basic();
        test_strobe();
        test_back_to_back();
        test_range();
        test_wait_states();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
